// File: rtl/alu_seq_if.sv
// Handshake/result bundle for alu_seq: the master issues operations and
// drains results, the slave is the ALU.
interface alu_seq_if #(
    parameter int unsigned WIDTH = 8
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic [WIDTH-1:0] out_hi;
    logic             flag_c;
    logic             flag_z;
    logic             flag_n;
    logic             flag_v;
    logic             op_err;

    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, out, out_hi, flag_c, flag_z, flag_n, flag_v, op_err
    );

    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, out, out_hi, flag_c, flag_z, flag_n, flag_v, op_err
    );
endinterface

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshake and an iterative shift-and-add multiplier.
// Optional macro ALU_SAT_EN makes ADD/SUB saturate unsigned.
module alu_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic     clk,
    input  logic     rst_n,
    alu_seq_if.slave bus
);
    localparam int unsigned CntW = $clog2(WIDTH + 1);
    localparam int unsigned Msb  = WIDTH - 1;

    typedef enum logic [1:0] {StIdle, StMul, StDone} state_e;

    state_e           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_out, w_out_nxt, r_out_hi, w_out_hi_nxt;
    logic             r_c, w_c_nxt, r_z, w_z_nxt, r_n, w_n_nxt, r_v, w_v_nxt;
    logic             r_err, w_err_nxt;
    logic [WIDTH-1:0] r_mcand, w_mcand_nxt, r_mplier, w_mplier_nxt, r_acc, w_acc_nxt;
    logic [CntW-1:0]  r_cnt, w_cnt_nxt;

    logic [WIDTH:0]   w_sum, w_diff, w_step;
    logic [WIDTH-1:0] w_add_res, w_sub_res, w_mpl_step, w_res;
    logic             w_res_c, w_res_v, w_res_err;

    assign w_sum  = {1'b0, bus.a} + {1'b0, bus.b};
    assign w_diff = {1'b0, bus.a} - {1'b0, bus.b};

`ifdef ALU_SAT_EN
    assign w_add_res = w_sum[WIDTH] ? '1 : w_sum[WIDTH-1:0];
    assign w_sub_res = w_diff[WIDTH] ? '0 : w_diff[WIDTH-1:0];
`else
    assign w_add_res = w_sum[WIDTH-1:0];
    assign w_sub_res = w_diff[WIDTH-1:0];
`endif

    // One multiply step: {acc, mplier} shifts right with the conditional add folded in.
    assign w_step     = {1'b0, r_acc} + {1'b0, {WIDTH{r_mplier[0]}} & r_mcand};
    assign w_mpl_step = {w_step[0], r_mplier[WIDTH-1:1]};

    always_comb begin
        w_res     = '0;
        w_res_c   = 1'b0;
        w_res_v   = 1'b0;
        w_res_err = 1'b0;
        case (bus.op)
            4'h0: begin
                w_res   = w_add_res;
                w_res_c = w_sum[WIDTH];
                w_res_v = (bus.a[Msb] == bus.b[Msb]) && (w_sum[Msb] != bus.a[Msb]);
            end
            4'h1: begin
                w_res   = w_sub_res;
                w_res_c = w_diff[WIDTH];
                w_res_v = (bus.a[Msb] != bus.b[Msb]) && (w_diff[Msb] != bus.a[Msb]);
            end
            4'h2: w_res = bus.a & bus.b;
            4'h3: w_res = bus.a | bus.b;
            4'h4: w_res = bus.a ^ bus.b;
            4'h5: begin
                w_res   = {bus.a[WIDTH-2:0], 1'b0};
                w_res_c = bus.a[Msb];
            end
            4'h6: begin
                w_res   = {1'b0, bus.a[WIDTH-1:1]};
                w_res_c = bus.a[0];
            end
            4'h7: w_res = bus.a;
            4'h8: w_res = '0;
            4'h9: w_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            4'hA: begin
                w_res   = {bus.a[WIDTH-2:0], bus.a[Msb]};
                w_res_c = bus.a[Msb];
            end
            4'hB: begin
                w_res   = {bus.a[0], bus.a[WIDTH-1:1]};
                w_res_c = bus.a[0];
            end
            default: w_res_err = 1'b1;
        endcase
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_out_nxt    = r_out;
        w_out_hi_nxt = r_out_hi;
        w_c_nxt      = r_c;
        w_z_nxt      = r_z;
        w_n_nxt      = r_n;
        w_v_nxt      = r_v;
        w_err_nxt    = r_err;
        w_mcand_nxt  = r_mcand;
        w_mplier_nxt = r_mplier;
        w_acc_nxt    = r_acc;
        w_cnt_nxt    = r_cnt;
        unique case (r_state)
            StIdle: begin
                if (bus.in_valid) begin
                    if (bus.op == 4'h8) begin
                        w_mcand_nxt  = bus.a;
                        w_mplier_nxt = bus.b;
                        w_acc_nxt    = '0;
                        w_cnt_nxt    = CntW'(WIDTH);
                        w_state_nxt  = StMul;
                    end else begin
                        w_out_nxt    = w_res;
                        w_out_hi_nxt = '0;
                        w_c_nxt      = w_res_c;
                        w_z_nxt      = ~|w_res;
                        w_n_nxt      = w_res[Msb];
                        w_v_nxt      = w_res_v;
                        w_err_nxt    = w_res_err;
                        w_state_nxt  = StDone;
                    end
                end
            end
            StMul: begin
                w_acc_nxt    = w_step[WIDTH:1];
                w_mplier_nxt = w_mpl_step;
                w_cnt_nxt    = r_cnt - CntW'(1);
                // Last step: publish the product in the same edge.
                if (r_cnt == CntW'(1)) begin
                    w_out_nxt    = w_mpl_step;
                    w_out_hi_nxt = w_step[WIDTH:1];
                    w_c_nxt      = |w_step[WIDTH:1];
                    w_z_nxt      = ~|{w_step[WIDTH:1], w_mpl_step};
                    w_n_nxt      = w_mpl_step[Msb];
                    w_v_nxt      = 1'b0;
                    w_err_nxt    = 1'b0;
                    w_state_nxt  = StDone;
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    w_state_nxt = StIdle;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= StIdle;
            r_out    <= '0;
            r_out_hi <= '0;
            r_c      <= 1'b0;
            r_z      <= 1'b0;
            r_n      <= 1'b0;
            r_v      <= 1'b0;
            r_err    <= 1'b0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_out    <= w_out_nxt;
            r_out_hi <= w_out_hi_nxt;
            r_c      <= w_c_nxt;
            r_z      <= w_z_nxt;
            r_n      <= w_n_nxt;
            r_v      <= w_v_nxt;
            r_err    <= w_err_nxt;
            r_mcand  <= w_mcand_nxt;
            r_mplier <= w_mplier_nxt;
            r_acc    <= w_acc_nxt;
            r_cnt    <= w_cnt_nxt;
        end
    end

    assign bus.in_ready  = (r_state == StIdle);
    assign bus.out_valid = (r_state == StDone);
    assign bus.out       = r_out;
    assign bus.out_hi    = r_out_hi;
    assign bus.flag_c    = r_c;
    assign bus.flag_z    = r_z;
    assign bus.flag_n    = r_n;
    assign bus.flag_v    = r_v;
    assign bus.op_err    = r_err;
endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: a WIDTH=4 and a WIDTH=8 instance on a shared clock/reset.
module tb_alu_seq;
    logic clk;
    logic rst_n;
    int   n_cmp = 0;
    int   n_mis = 0;

    alu_seq_if #(.WIDTH(4)) bus4 ();
    alu_seq_if #(.WIDTH(8)) bus8 ();

    alu_seq #(.WIDTH(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
    alu_seq #(.WIDTH(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input bit w8, input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] op, input logic v);
        if (w8) begin
            bus8.a = a; bus8.b = b; bus8.op = op; bus8.in_valid = v;
        end else begin
            bus4.a = a[3:0]; bus4.b = b[3:0]; bus4.op = op; bus4.in_valid = v;
        end
    endtask

    task automatic set_valid(input bit w8, input logic v);
        if (w8) bus8.in_valid = v; else bus4.in_valid = v;
    endtask

    task automatic set_oready(input bit w8, input logic v);
        if (w8) bus8.out_ready = v; else bus4.out_ready = v;
    endtask

    function automatic logic [7:0] got_out(input bit w8);
        return w8 ? bus8.out : {4'h0, bus4.out};
    endfunction

    function automatic logic [7:0] got_hi(input bit w8);
        return w8 ? bus8.out_hi : {4'h0, bus4.out_hi};
    endfunction

    // Flags packed as {C, Z, N, V, op_err}.
    function automatic logic [4:0] got_flags(input bit w8);
        if (w8) return {bus8.flag_c, bus8.flag_z, bus8.flag_n, bus8.flag_v, bus8.op_err};
        return {bus4.flag_c, bus4.flag_z, bus4.flag_n, bus4.flag_v, bus4.op_err};
    endfunction

    function automatic logic got_valid(input bit w8);
        return w8 ? bus8.out_valid : bus4.out_valid;
    endfunction

    function automatic logic got_ready(input bit w8);
        return w8 ? bus8.in_ready : bus4.in_ready;
    endfunction

    task automatic run_op(input string tag, input bit w8, input logic [7:0] a, input logic [7:0] b,
                          input logic [3:0] op, input logic [7:0] eo, input logic [7:0] eh,
                          input logic [4:0] ef, input int elat, input int hold, input bit poke);
        int lat;
        @(negedge clk);
        drive(w8, a, b, op, 1'b1);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 1) set_valid(w8, 1'b0);
            if (poke && lat == 2) drive(w8, 8'h00, 8'h00, 4'h0, 1'b1);
            if (poke && lat == 3) set_valid(w8, 1'b0);
        end while (!got_valid(w8) && lat < 64);
        set_valid(w8, 1'b0);
        check({tag, ".lat"}, lat, elat);
        check({tag, ".out"}, got_out(w8), eo);
        check({tag, ".hi"}, got_hi(w8), eh);
        check({tag, ".flags"}, got_flags(w8), ef);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check({tag, ".hold"}, {got_valid(w8), got_ready(w8), got_out(w8), got_flags(w8)},
                  {1'b1, 1'b0, eo, ef});
        end
        @(negedge clk);
        set_oready(w8, 1'b1);
        @(posedge clk);
        #1;
        set_oready(w8, 1'b0);
        check({tag, ".drain"}, {got_valid(w8), got_ready(w8)}, 2'b01);
        check({tag, ".keep"}, {got_out(w8), got_flags(w8)}, {eo, ef});
    endtask

    initial begin
        logic       seen;
        logic [7:0] add_sat_o, sub_neg_o;
        logic [4:0] sub_neg_f;
`ifdef ALU_SAT_EN
        add_sat_o = 8'h0F; sub_neg_o = 8'h00; sub_neg_f = 5'b11000;
`else
        add_sat_o = 8'h0A; sub_neg_o = 8'h0E; sub_neg_f = 5'b10100;
`endif
        rst_n = 1'b0;
        drive(1'b0, 8'h00, 8'h00, 4'h0, 1'b0);
        drive(1'b1, 8'h00, 8'h00, 4'h0, 1'b0);
        set_oready(1'b0, 1'b0);
        set_oready(1'b1, 1'b0);
        #12;
        check("rst4", {got_valid(0), got_ready(0), got_out(0), got_hi(0), got_flags(0)},
              {1'b0, 1'b1, 8'h00, 8'h00, 5'b0});
        check("rst8", {got_valid(1), got_ready(1), got_out(1), got_hi(1), got_flags(1)},
              {1'b0, 1'b1, 8'h00, 8'h00, 5'b0});
        @(negedge clk);
        rst_n = 1'b1;

        run_op("add_ovf", 0, 8'h05, 8'h03, 4'h0, 8'h08, 8'h00, 5'b00110, 1, 5, 0);
        run_op("add_cy",  0, 8'h0F, 8'h0B, 4'h0, add_sat_o, 8'h00, 5'b10100, 1, 0, 0);
        run_op("sub",     0, 8'h0F, 8'h0B, 4'h1, 8'h04, 8'h00, 5'b00000, 1, 0, 0);
        run_op("sub_bw",  0, 8'h03, 8'h05, 4'h1, sub_neg_o, 8'h00, sub_neg_f, 1, 0, 0);
        run_op("slt_f",   0, 8'h0F, 8'h0B, 4'h9, 8'h00, 8'h00, 5'b01000, 1, 0, 0);
        run_op("slt_t",   0, 8'h0B, 8'h01, 4'h9, 8'h01, 8'h00, 5'b00000, 1, 0, 0);
        run_op("and",     0, 8'h0C, 8'h0A, 4'h2, 8'h08, 8'h00, 5'b00100, 1, 0, 0);
        run_op("or",      0, 8'h0C, 8'h0A, 4'h3, 8'h0E, 8'h00, 5'b00100, 1, 0, 0);
        run_op("xor",     0, 8'h0C, 8'h0A, 4'h4, 8'h06, 8'h00, 5'b00000, 1, 0, 0);
        run_op("shr",     0, 8'h05, 8'h00, 4'h6, 8'h02, 8'h00, 5'b10000, 1, 0, 0);
        run_op("pass",    0, 8'h09, 8'h00, 4'h7, 8'h09, 8'h00, 5'b00100, 1, 0, 0);
        run_op("mul4",    0, 8'h0F, 8'h0B, 4'h8, 8'h05, 8'h0A, 5'b10000, 5, 2, 1);
        run_op("mul4_z",  0, 8'h00, 8'h0A, 4'h8, 8'h00, 8'h00, 5'b01000, 5, 0, 0);
        run_op("shl8",    1, 8'h81, 8'h00, 4'h5, 8'h02, 8'h00, 5'b10000, 1, 0, 0);
        run_op("ror8",    1, 8'h81, 8'h00, 4'hB, 8'hC0, 8'h00, 5'b10100, 1, 0, 0);
        run_op("rol8",    1, 8'h81, 8'h00, 4'hA, 8'h03, 8'h00, 5'b10000, 1, 0, 0);
        run_op("undef8",  1, 8'h81, 8'h22, 4'hD, 8'h00, 8'h00, 5'b01001, 1, 0, 0);
        run_op("mul8",    1, 8'h10, 8'h10, 4'h8, 8'h00, 8'h01, 5'b10000, 9, 0, 0);

        // Abandon a multiply with an asynchronous reset between clock edges.
        @(negedge clk);
        drive(1'b0, 8'h0F, 8'h0B, 4'h8, 1'b1);
        @(posedge clk);
        #1;
        set_valid(1'b0, 1'b0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("rst_mid", {got_valid(0), got_ready(0), got_out(0), got_hi(0), got_flags(0)},
              {1'b0, 1'b1, 8'h00, 8'h00, 5'b0});
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1;
            seen = seen | got_valid(0);
        end
        check("rst_no_result", {seen, got_ready(0)}, 2'b01);
        run_op("post_rst", 0, 8'h05, 8'h03, 4'h0, 8'h08, 8'h00, 5'b00110, 1, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
